// File: rtl/irq_ctl_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// FSM encoding, reset vector base and the status read-back layout.
package irq_ctl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ID_W   = 5;

  localparam logic [ADDR_W-1:0] REG_CTRL  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_MASK  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_EDGE  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PEND  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_VBASE = 3'd4;
  localparam logic [ADDR_W-1:0] REG_EOI   = 3'd5;

  localparam logic [DATA_W-1:0] RESET_VBASE_DEF = 32'h0000_0050;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  // Layout of the STAT word returned from the EOI/STAT index
  typedef struct packed {
    logic [21:0]     rsvd_hi;
    logic [1:0]      state;
    logic [2:0]      rsvd_lo;
    logic [ID_W-1:0] id;
  } stat_t;

endpackage

// File: rtl/irq_ctl_if.sv
// Software register port plus the request/acknowledge path to the RF stage.
interface irq_ctl_if;
  import irq_ctl_pkg::*;

  logic              cs_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] din_i;
  logic [DATA_W-1:0] dout_o;
  logic              irq_o;
  logic [DATA_W-1:0] irq_addr_o;
  logic              iack_i;
  logic              busy_o;

  modport slave (
    input  cs_i, we_i, addr_i, din_i, iack_i,
    output dout_o, irq_o, irq_addr_o, busy_o
  );

  modport master (
    output cs_i, we_i, addr_i, din_i, iack_i,
    input  dout_o, irq_o, irq_addr_o, busy_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
  import irq_ctl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0] i_req,
  output logic            o_valid_c,
  output logic [ID_W-1:0] o_idx_c
);

  // Scan from the top down so the lowest set index is the last to assign
  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid_c = 1'b1;
        o_idx_c   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: pending/mask/edge registers, fixed-priority select and
// a single in-flight request sequenced through REQ -> SVC -> EOI.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int unsigned       NSRC        = 8,
  parameter logic [DATA_W-1:0] RESET_VBASE = RESET_VBASE_DEF,
  parameter int unsigned       VEC_SHIFT   = 3
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic [NSRC-1:0] src_i,
  irq_ctl_if.slave        bus
);

  logic              r_gie;
  logic [NSRC-1:0]   r_mask;
  logic [NSRC-1:0]   r_edge;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_src_q;
  logic [DATA_W-1:0] r_vbase;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_irq_addr;
  logic [ID_W-1:0]   r_cur_id;
  logic              r_irq;
  logic              r_busy;
  state_e            r_state;

  state_e            w_nxt_state;
  logic [ID_W-1:0]   w_nxt_id;
  logic [DATA_W-1:0] w_nxt_addr;
  logic              w_nxt_irq;
  logic              w_nxt_busy;

  logic              w_wr;
  logic              w_rd;
  logic              w_eoi;
  logic              w_ack;
  logic [NSRC-1:0]   w_cand;
  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_w1c;
  logic [NSRC-1:0]   w_ack_clr;
  logic [NSRC-1:0]   w_pend_nxt;
  logic              w_win_vld;
  logic [ID_W-1:0]   w_win_id;
  logic [DATA_W-1:0] w_rd_data;
  stat_t             w_stat;

  assign w_wr   = bus.cs_i && bus.we_i;
  assign w_rd   = bus.cs_i && !bus.we_i;
  assign w_eoi  = w_wr && (bus.addr_i == REG_EOI);
  assign w_ack  = (r_state == ST_REQ) && bus.iack_i;
  assign w_cand = r_pend & r_mask;

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .i_req     (w_cand),
    .o_valid_c (w_win_vld),
    .o_idx_c   (w_win_id)
  );

  // Edge bits: a new rising edge wins over a W1C or acknowledge clear
  assign w_rise     = src_i & ~r_src_q;
  assign w_w1c      = (w_wr && (bus.addr_i == REG_PEND)) ? bus.din_i[NSRC-1:0] : '0;
  assign w_ack_clr  = w_ack ? (NSRC'(1) << r_cur_id) : '0;
  assign w_pend_nxt = (~r_edge & src_i)
                    | (r_edge & (w_rise | (r_pend & ~(w_w1c | w_ack_clr))));

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_src_q <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_src_q <= src_i;
    end
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_gie   <= 1'b0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_vbase <= RESET_VBASE;
    end else if (w_wr) begin
      case (bus.addr_i)
        REG_CTRL:  r_gie   <= bus.din_i[0];
        REG_MASK:  r_mask  <= bus.din_i[NSRC-1:0];
        REG_EDGE:  r_edge  <= bus.din_i[NSRC-1:0];
        REG_VBASE: r_vbase <= bus.din_i;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_stat       = '0;
    w_stat.state = r_state;
    w_stat.id    = r_cur_id;
    w_rd_data    = '0;
    case (bus.addr_i)
      REG_CTRL:  w_rd_data = DATA_W'(r_gie);
      REG_MASK:  w_rd_data = DATA_W'(r_mask);
      REG_EDGE:  w_rd_data = DATA_W'(r_edge);
      REG_PEND:  w_rd_data = DATA_W'(r_pend);
      REG_VBASE: w_rd_data = r_vbase;
      REG_EOI:   w_rd_data = w_stat;
      default:   w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= w_rd_data;
    end
  end

  // FSM state and the registered request outputs
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cur_id   <= '0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
      r_irq_addr <= RESET_VBASE;
    end else begin
      r_state    <= w_nxt_state;
      r_cur_id   <= w_nxt_id;
      r_irq      <= w_nxt_irq;
      r_busy     <= w_nxt_busy;
      r_irq_addr <= w_nxt_addr;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_id    = r_cur_id;
    w_nxt_addr  = r_irq_addr;
    w_nxt_irq   = r_irq;
    w_nxt_busy  = r_busy;
    case (r_state)
      ST_IDLE: begin
        w_nxt_irq  = 1'b0;
        w_nxt_busy = 1'b0;
        if (r_gie && w_win_vld) begin
          w_nxt_state = ST_REQ;
          w_nxt_id    = w_win_id;
          w_nxt_addr  = r_vbase + (DATA_W'(w_win_id) << VEC_SHIFT);
          w_nxt_irq   = 1'b1;
          w_nxt_busy  = 1'b1;
        end
      end
      // Committed request: held until acknowledged regardless of source/mask/gie
      ST_REQ: begin
        w_nxt_irq  = 1'b1;
        w_nxt_busy = 1'b1;
        if (bus.iack_i) begin
          w_nxt_state = ST_SVC;
          w_nxt_irq   = 1'b0;
        end
      end
      ST_SVC: begin
        w_nxt_irq  = 1'b0;
        w_nxt_busy = 1'b1;
        if (w_eoi) begin
          w_nxt_state = ST_IDLE;
          w_nxt_busy  = 1'b0;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_irq   = 1'b0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  assign bus.dout_o     = r_dout;
  assign bus.irq_o      = r_irq;
  assign bus.irq_addr_o = r_irq_addr;
  assign bus.busy_o     = r_busy;

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: expected reads and request vectors are queued
// by the stimulus and consumed by a negedge monitor.
module tb_irq_ctl;
  import irq_ctl_pkg::*;

  localparam int unsigned NSRC = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NSRC-1:0] src_i;

  irq_ctl_if bus();

  irq_ctl #(
    .NSRC        (NSRC),
    .RESET_VBASE (32'h0000_0050),
    .VEC_SHIFT   (3)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .src_i (src_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [31:0] exp_irq_q[$];
  string       irq_name_q[$];

  logic rd_issued = 1'b0;
  logic prev_irq  = 1'b0;

  always @(posedge clk) rd_issued <= bus.cs_i && !bus.we_i;

  // Monitor: compares read data and every rising request against the queues
  always @(negedge clk) begin
    if (rd_issued === 1'b1) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: dout=%h with no expected read", bus.dout_o);
      end else begin
        automatic logic [31:0] e = exp_rd_q.pop_front();
        automatic string nm = rd_name_q.pop_front();
        if (bus.dout_o !== e) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", nm, bus.dout_o, e);
        end
      end
    end
    if (bus.irq_o === 1'b1 && prev_irq !== 1'b1) begin
      n_checks++;
      if (exp_irq_q.size() == 0) begin
        n_errors++;
        $display("FAIL irq_unexpected: irq rose with addr=%h", bus.irq_addr_o);
      end else begin
        automatic logic [31:0] e = exp_irq_q.pop_front();
        automatic string nm = irq_name_q.pop_front();
        if (bus.irq_addr_o !== e) begin
          n_errors++;
          $display("FAIL %s: irq_addr got %h expected %h", nm, bus.irq_addr_o, e);
        end
      end
    end
    prev_irq = bus.irq_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.cs_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.din_i  = d;
    @(posedge clk);
    #1;
    bus.cs_i = 1'b0;
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_rd_q.push_back(e);
    rd_name_q.push_back(nm);
    bus.cs_i   = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    @(posedge clk);
    #1;
    bus.cs_i = 1'b0;
  endtask

  task automatic expect_irq(input logic [31:0] a, input string nm);
    exp_irq_q.push_back(a);
    irq_name_q.push_back(nm);
  endtask

  task automatic wait_irq(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.irq_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: irq_o did not rise within 30 cycles", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    bus.iack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.iack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    src_i      = '0;
    bus.cs_i   = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.din_i  = '0;
    bus.iack_i = 1'b0;
    cyc(3);
    rst_i = 1'b0;

    // Reset values
    chk("rst_irq", 32'(bus.irq_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    chk("rst_irq_addr", bus.irq_addr_o, 32'h50);
    rd(REG_CTRL,  32'h0,  "rst_ctrl");
    rd(REG_MASK,  32'h0,  "rst_mask");
    rd(REG_EDGE,  32'h0,  "rst_edge");
    rd(REG_PEND,  32'h0,  "rst_pend");
    rd(REG_VBASE, 32'h50, "rst_vbase");
    rd(REG_EOI,   32'h0,  "rst_stat");
    rd(3'd6,      32'h0,  "rst_reg6");
    cyc(2);

    // Level sources 2 and 5: source 2 wins, re-requested after EOI
    wr(REG_MASK, 32'hFF);
    wr(REG_CTRL, 32'h1);
    expect_irq(32'h60, "lvl_req_id2");
    src_i = 8'h24;
    wait_irq("lvl_req_id2");
    chk("lvl_busy_req", 32'(bus.busy_o), 32'h1);
    ack();
    chk("lvl_irq_after_ack", 32'(bus.irq_o), 32'h0);
    rd(REG_EOI, 32'h202, "lvl_stat_svc_id2");
    chk("lvl_busy_svc", 32'(bus.busy_o), 32'h1);
    expect_irq(32'h60, "lvl_rereq_id2");
    wr(REG_EOI, 32'h0);
    wait_irq("lvl_rereq_id2");
    ack();
    src_i = 8'h00;
    wr(REG_EOI, 32'h0);
    cyc(2);
    chk("lvl_idle_busy", 32'(bus.busy_o), 32'h0);

    // Edge source 0 pulsed while source 1 is in service
    wr(REG_EDGE, 32'h01);
    wr(REG_MASK, 32'h02);
    expect_irq(32'h58, "edge_req_id1");
    src_i = 8'h02;
    wait_irq("edge_req_id1");
    ack();
    src_i = 8'h00;
    wr(REG_MASK, 32'h01);
    src_i = 8'h01;
    cyc(1);
    src_i = 8'h00;
    cyc(1);
    rd(REG_PEND, 32'h01, "edge_pend_retained");
    rd(REG_EOI, 32'h201, "edge_stat_svc_id1");
    expect_irq(32'h50, "edge_req_id0");
    wr(REG_EOI, 32'h0);
    wait_irq("edge_req_id0");
    ack();
    rd(REG_EOI, 32'h200, "edge_stat_svc_id0");
    rd(REG_PEND, 32'h00, "edge_pend_ack_clr");
    wr(REG_EOI, 32'h0);
    cyc(2);

    // Committed request for id 3 survives source drop, mask, gie and VBASE write
    wr(REG_EDGE, 32'h00);
    wr(REG_MASK, 32'h08);
    expect_irq(32'h68, "commit_req_id3");
    src_i = 8'h08;
    wait_irq("commit_req_id3");
    src_i = 8'h00;
    wr(REG_MASK, 32'h00);
    wr(REG_CTRL, 32'h00);
    wr(REG_VBASE, 32'h1000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("commit_irq_held", 32'(bus.irq_o), 32'h1);
      chk("commit_addr_held", bus.irq_addr_o, 32'h68);
    end
    @(posedge clk);
    #1;
    ack();
    rd(REG_EOI, 32'h203, "commit_stat_svc_id3");
    wr(REG_EOI, 32'h0);
    rd(REG_EOI, 32'h003, "commit_stat_idle");
    rd(REG_VBASE, 32'h1000, "commit_vbase");

    // Same-cycle W1C and rising edge on source 1: set wins
    wr(REG_EDGE, 32'h02);
    src_i = 8'h02;
    cyc(1);
    src_i = 8'h00;
    cyc(1);
    rd(REG_PEND, 32'h02, "w1c_pend_set");
    src_i = 8'h02;
    wr(REG_PEND, 32'h02);
    src_i = 8'h00;
    rd(REG_PEND, 32'h02, "w1c_race_set_wins");
    wr(REG_PEND, 32'h02);
    rd(REG_PEND, 32'h00, "w1c_clear");

    // Reset during REQ drops the request without an acknowledge
    wr(REG_EDGE, 32'h00);
    wr(REG_MASK, 32'h01);
    wr(REG_CTRL, 32'h01);
    expect_irq(32'h1000, "rstreq_id0");
    src_i = 8'h01;
    wait_irq("rstreq_id0");
    rst_i = 1'b1;
    cyc(1);
    rst_i = 1'b0;
    src_i = 8'h00;
    @(negedge clk);
    chk("rstreq_irq_low", 32'(bus.irq_o), 32'h0);
    chk("rstreq_busy_low", 32'(bus.busy_o), 32'h0);
    chk("rstreq_irq_addr", bus.irq_addr_o, 32'h50);
    @(posedge clk);
    #1;
    rd(REG_EOI,   32'h0,  "rstreq_stat");
    rd(REG_VBASE, 32'h50, "rstreq_vbase");
    rd(REG_CTRL,  32'h0,  "rstreq_ctrl");
    rd(REG_MASK,  32'h0,  "rstreq_mask");
    rd(REG_PEND,  32'h0,  "rstreq_pend");
    cyc(4);

    n_checks++;
    if (exp_rd_q.size() != 0 || exp_irq_q.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: reads left %0d requests left %0d expected 0 and 0",
               exp_rd_q.size(), exp_irq_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
